// File: rtl/jtframe_upload_pkg.sv
// Shared types for the HPS uploader.
// FSM state encoding and the out-of-range fill byte.
package jtframe_upload_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    localparam logic [7:0] FILL_BYTE = 8'hFF;

    function automatic logic [7:0] byte_sel(
        input logic [15:0] w,
        input logic        hi
    );
        return hi ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/jtframe_uploader_if.sv
// 16-bit word fetch bus between the uploader and memory.
// The uploader is the master; memory acks then flags data ready.
interface jtframe_uploader_if #(
    parameter int AW = 22
) ();
    logic          mem_req;
    logic [AW-2:0] mem_addr;
    logic          mem_ack;
    logic          mem_rdy;
    logic [15:0]   mem_data;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdy, mem_data
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdy, mem_data
    );
endinterface

// File: rtl/jtframe_uploader.sv
// Serves hps_io byte reads from 16-bit memory through a one-word cache.
// Out-of-range reads and fetch timeouts return the fill byte.
module jtframe_uploader
    import jtframe_upload_pkg::*;
#(
    parameter int            AW        = 22,
    parameter logic [AW-1:0] DUMP_SIZE = AW'(22'h2000),
    parameter int            TIMEOUT   = 255
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ioctl_upload,
    input  logic               ioctl_rd,
    input  logic [AW-1:0]      ioctl_addr,
    output logic [7:0]         ioctl_din,
    output logic               ioctl_wait,
    jtframe_uploader_if.master mem,
    output logic               upload_done,
    output logic               err
);

    localparam int            CW   = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CMAX = '1;

    state_t        st, st_nx;
    logic          upload_q;
    logic          sel, sel_nx;
    logic [AW-2:0] cache_addr, caddr_nx;
    logic [AW-2:0] maddr_nx;
    logic [15:0]   cache_data, cdata_nx;
    logic          cache_valid, cval_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic          req_nx, wait_nx;
    logic          done_nx, err_nx;
    logic [7:0]    din_nx;
    logic          rise, fall, oob, hit, take;

    assign rise = ioctl_upload & ~upload_q;
    assign fall = ~ioctl_upload & upload_q;
    assign oob  = ioctl_addr >= DUMP_SIZE;
    // A rising session edge invalidates the cache in the same cycle
    assign hit  = ~oob & cache_valid & ~rise &
                  (cache_addr == ioctl_addr[AW-1:1]);
    assign cnt_inc = (cnt == CMAX) ? cnt : cnt + CW'(1);
    assign take = ioctl_upload & mem.mem_rdy &
                  ((st == ST_WAIT) |
                   ((st == ST_REQ) & mem.mem_ack));

    always_comb begin
        st_nx    = st;
        req_nx   = mem.mem_req;
        maddr_nx = mem.mem_addr;
        wait_nx  = ioctl_wait;
        din_nx   = ioctl_din;
        done_nx  = 1'b0;
        err_nx   = err;
        caddr_nx = cache_addr;
        cdata_nx = cache_data;
        cval_nx  = cache_valid;
        cnt_nx   = cnt;
        sel_nx   = sel;
        if (rise) begin
            cval_nx = 1'b0;
            err_nx  = 1'b0;
        end
        if (fall) begin
            done_nx = 1'b1;
            st_nx   = ST_IDLE;
            req_nx  = 1'b0;
            wait_nx = 1'b0;
            cval_nx = 1'b0;
        end else if (ioctl_upload) begin
            unique case (st)
                ST_IDLE: if (ioctl_rd) begin
                    unique case (1'b1)
                        oob: din_nx = FILL_BYTE;
                        hit: din_nx = byte_sel(cache_data,
                                               ioctl_addr[0]);
                        default: begin
                            req_nx   = 1'b1;
                            maddr_nx = ioctl_addr[AW-1:1];
                            sel_nx   = ioctl_addr[0];
                            wait_nx  = 1'b1;
                            st_nx    = ST_REQ;
                        end
                    endcase
                end
                ST_REQ: begin
                    if (ioctl_rd) err_nx = 1'b1;
                    if (mem.mem_ack) begin
                        req_nx = 1'b0;
                        cnt_nx = '0;
                        st_nx  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ioctl_rd) err_nx = 1'b1;
                    if (!mem.mem_rdy) begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc >= TMO) begin
                            din_nx  = FILL_BYTE;
                            err_nx  = 1'b1;
                            cval_nx = 1'b0;
                            wait_nx = 1'b0;
                            st_nx   = ST_IDLE;
                        end
                    end
                end
                default: st_nx = ST_IDLE;
            endcase
            if (take) begin
                caddr_nx = mem.mem_addr;
                cdata_nx = mem.mem_data;
                cval_nx  = 1'b1;
                din_nx   = byte_sel(mem.mem_data, sel);
                wait_nx  = 1'b0;
                st_nx    = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= ST_IDLE;
            upload_q     <= 1'b0;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            ioctl_wait   <= 1'b0;
            ioctl_din    <= FILL_BYTE;
            upload_done  <= 1'b0;
            err          <= 1'b0;
            cache_addr   <= '0;
            cache_data   <= '0;
            cache_valid  <= 1'b0;
            cnt          <= '0;
            sel          <= 1'b0;
        end else begin
            st           <= st_nx;
            upload_q     <= ioctl_upload;
            mem.mem_req  <= req_nx;
            mem.mem_addr <= maddr_nx;
            ioctl_wait   <= wait_nx;
            ioctl_din    <= din_nx;
            upload_done  <= done_nx;
            err          <= err_nx;
            cache_addr   <= caddr_nx;
            cache_data   <= cdata_nx;
            cache_valid  <= cval_nx;
            cnt          <= cnt_nx;
            sel          <= sel_nx;
        end
    end

endmodule

// File: tb/tb_jtframe_uploader.sv
// Bench for jtframe_uploader: vector table, corner sequences,
// and random reads against a transaction-level cache model.
module tb_jtframe_uploader;

    localparam int AW  = 22;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ioctl_upload = 1'b0;
    logic          ioctl_rd = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          upload_done;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    jtframe_uploader_if #(.AW(AW)) mem ();

    jtframe_uploader #(
        .AW(AW),
        .DUMP_SIZE(22'h2000),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait),
        .mem(mem),
        .upload_done(upload_done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        int            ack_d;
        int            rdy_d;
        logic [7:0]    exp_din;
        logic          exp_req;
        int            exp_wc;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Acts as memory while ioctl_wait is high; rdy_d<0 means
    // rdy together with ack, a large rdy_d means never.
    task automatic serve(input int ack_d, input int rdy_d,
                         input logic [15:0] d, input logic rd_dur,
                         output int wc);
        int rq = 0;
        int wt = 0;
        wc = 0;
        while (ioctl_wait && wc < 400) begin
            wc++;
            ioctl_rd = rd_dur && (wc == 1);
            mem.mem_ack = 1'b0;
            mem.mem_rdy = 1'b0;
            if (mem.mem_req) begin
                if (rq == ack_d) begin
                    mem.mem_ack = 1'b1;
                    if (rdy_d < 0) begin
                        mem.mem_rdy  = 1'b1;
                        mem.mem_data = d;
                    end
                end
                rq++;
            end else begin
                if (wt == rdy_d) begin
                    mem.mem_rdy  = 1'b1;
                    mem.mem_data = d;
                end
                wt++;
            end
            @(negedge clk);
        end
        ioctl_rd    = 1'b0;
        mem.mem_ack = 1'b0;
        mem.mem_rdy = 1'b0;
        if (wc >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL serve_bound: wait still high after %0d", wc);
        end
    endtask

    task automatic rd_byte(input logic [AW-1:0] a,
                           input logic [15:0] d,
                           input int ack_d, input int rdy_d,
                           input logic rd_dur,
                           output logic got, output int wc);
        @(negedge clk);
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        @(negedge clk);
        ioctl_rd = 1'b0;
        got = mem.mem_req;
        if (got) chk("mem_addr", 32'(mem.mem_addr), 32'(a[AW-1:1]));
        serve(ack_d, rdy_d, d, rd_dur, wc);
    endtask

    task automatic new_session();
        @(negedge clk);
        ioctl_upload = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(upload_done), 1);
        @(negedge clk);
        chk("done_single", 32'(upload_done), 0);
        ioctl_upload = 1'b1;
        @(negedge clk);
        chk("err_cleared", 32'(err), 0);
    endtask

    logic          got;
    int            wc;
    logic          mv, merr, e_req, e_oob;
    logic [AW-2:0] mw;
    logic [15:0]   md;
    logic [7:0]    eb;
    int            ewc;

    initial begin
        mem.mem_ack  = 1'b0;
        mem.mem_rdy  = 1'b0;
        mem.mem_data = '0;

        vecs[0] = '{22'h0010, 16'hBEEF, 0,  2, 8'hEF, 1'b1, 4};
        vecs[1] = '{22'h0011, 16'h0000, 0,  0, 8'hBE, 1'b0, 0};
        vecs[2] = '{22'h2000, 16'h0000, 0,  0, 8'hFF, 1'b0, 0};
        vecs[3] = '{22'h3FFFFF, 16'h0000, 0, 0, 8'hFF, 1'b0, 0};
        vecs[4] = '{22'h1FFF, 16'h1357, 2, -1, 8'h13, 1'b1, 3};
        vecs[5] = '{22'h1FFE, 16'h0000, 0,  0, 8'h57, 1'b0, 0};
        vecs[6] = '{22'h0010, 16'hCAFE, 1,  0, 8'hFE, 1'b1, 3};
        vecs[7] = '{22'h0011, 16'h0000, 0,  0, 8'hCA, 1'b0, 0};

        repeat (3) @(negedge clk);
        chk("rst_din", 32'(ioctl_din), 32'hFF);
        chk("rst_wait", 32'(ioctl_wait), 0);
        chk("rst_req", 32'(mem.mem_req), 0);
        chk("rst_maddr", 32'(mem.mem_addr), 0);
        chk("rst_done", 32'(upload_done), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        ioctl_upload = 1'b1;

        for (int i = 0; i < 8; i++) begin
            rd_byte(vecs[i].addr, vecs[i].data, vecs[i].ack_d,
                    vecs[i].rdy_d, 1'b0, got, wc);
            chk($sformatf("vec%0d_din", i), 32'(ioctl_din),
                32'(vecs[i].exp_din));
            chk($sformatf("vec%0d_req", i), 32'(got),
                32'(vecs[i].exp_req));
            chk($sformatf("vec%0d_wait", i), 32'(wc),
                32'(vecs[i].exp_wc));
            chk($sformatf("vec%0d_err", i), 32'(err), 0);
        end

        rd_byte(22'h0100, 16'h5A5A, 0, 99, 1'b0, got, wc);
        chk("tmo_wait", 32'(wc), 32'(1 + TMO));
        chk("tmo_din", 32'(ioctl_din), 32'hFF);
        chk("tmo_err", 32'(err), 1);
        rd_byte(22'h0100, 16'h0F1E, 0, 0, 1'b0, got, wc);
        chk("tmo_refetch", 32'(got), 1);
        chk("tmo_refetch_din", 32'(ioctl_din), 32'h1E);
        chk("err_sticky", 32'(err), 1);
        new_session();

        rd_byte(22'h0500, 16'h9911, 0, 1, 1'b1, got, wc);
        chk("busy_rd_err", 32'(err), 1);
        chk("busy_rd_din", 32'(ioctl_din), 32'h11);
        new_session();

        @(negedge clk);
        ioctl_rd   = 1'b1;
        ioctl_addr = 22'h0300;
        @(negedge clk);
        ioctl_rd = 1'b0;
        chk("abort_req", 32'(mem.mem_req), 1);
        mem.mem_ack = 1'b1;
        @(negedge clk);
        mem.mem_ack = 1'b0;
        chk("abort_inwait", 32'(ioctl_wait), 1);
        ioctl_upload = 1'b0;
        @(negedge clk);
        chk("abort_done", 32'(upload_done), 1);
        chk("abort_wait", 32'(ioctl_wait), 0);
        chk("abort_req0", 32'(mem.mem_req), 0);
        mem.mem_rdy  = 1'b1;
        mem.mem_data = 16'h1234;
        @(negedge clk);
        mem.mem_rdy = 1'b0;
        chk("abort_done1", 32'(upload_done), 0);
        chk("abort_late", 32'(ioctl_wait), 0);
        ioctl_upload = 1'b1;
        @(negedge clk);
        rd_byte(22'h0300, 16'h5678, 0, 0, 1'b0, got, wc);
        chk("abort_newreq", 32'(got), 1);
        chk("abort_newdin", 32'(ioctl_din), 32'h78);

        @(negedge clk);
        ioctl_rd   = 1'b1;
        ioctl_addr = 22'h0400;
        @(negedge clk);
        ioctl_rd = 1'b0;
        chk("arst_req", 32'(mem.mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_din", 32'(ioctl_din), 32'hFF);
        chk("arst_wait", 32'(ioctl_wait), 0);
        chk("arst_req0", 32'(mem.mem_req), 0);
        chk("arst_maddr", 32'(mem.mem_addr), 0);
        chk("arst_err", 32'(err), 0);
        @(negedge clk);
        rst_n       = 1'b1;
        mem.mem_ack = 1'b1;
        @(negedge clk);
        mem.mem_ack = 1'b0;
        chk("post_ack_req", 32'(mem.mem_req), 0);
        chk("post_ack_wait", 32'(ioctl_wait), 0);
        mem.mem_rdy  = 1'b1;
        mem.mem_data = 16'hAAAA;
        @(negedge clk);
        mem.mem_rdy = 1'b0;
        chk("stale_wait", 32'(ioctl_wait), 0);
        chk("stale_din", 32'(ioctl_din), 32'hFF);
        rd_byte(22'h0400, 16'h4321, 0, 0, 1'b0, got, wc);
        chk("post_rst_req", 32'(got), 1);
        chk("post_rst_din", 32'(ioctl_din), 32'h21);

        new_session();
        mv   = 1'b0;
        merr = 1'b0;
        mw   = '0;
        md   = '0;
        for (int i = 0; i < 150; i++) begin
            logic [AW-1:0] a;
            logic [15:0]   d;
            int            ad, rdd, r;
            if ($urandom_range(0, 9) == 0)
                a = AW'(22'h2000 + $urandom_range(0, 22'h3FDFFF));
            else
                a = AW'($urandom_range(0, 47));
            d  = 16'($urandom);
            ad = $urandom_range(0, 3);
            r  = $urandom_range(0, 12);
            rdd = (r == 0) ? -1 : (r == 12) ? 20 : r - 1;
            e_oob = a >= 22'h2000;
            e_req = !e_oob && !(mv && mw == a[AW-1:1]);
            ewc = 0;
            if (e_oob) begin
                eb = 8'hFF;
            end else if (!e_req) begin
                eb = a[0] ? md[15:8] : md[7:0];
            end else if (rdd >= TMO) begin
                eb   = 8'hFF;
                mv   = 1'b0;
                merr = 1'b1;
                ewc  = ad + 1 + TMO;
            end else begin
                mv  = 1'b1;
                mw  = a[AW-1:1];
                md  = d;
                eb  = a[0] ? d[15:8] : d[7:0];
                ewc = ad + 1 + ((rdd < 0) ? 0 : rdd + 1);
            end
            rd_byte(a, d, ad, rdd, 1'b0, got, wc);
            chk($sformatf("rnd%0d_din", i), 32'(ioctl_din), 32'(eb));
            chk($sformatf("rnd%0d_req", i), 32'(got), 32'(e_req));
            chk($sformatf("rnd%0d_wait", i), 32'(wc), 32'(ewc));
            chk($sformatf("rnd%0d_err", i), 32'(err), 32'(merr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtframe_uploader.md
JTFRAME_UPLOADER -- requirements
Module: jtframe_uploader

Interface
REQ-001 Parameter AW, default 22: width of ioctl_addr (byte address).
REQ-002 Parameter DUMP_SIZE, default 22'h2000: bytes readable; higher addresses return 8'hFF.
REQ-003 Parameter TIMEOUT, default 255: max clk cycles waited for mem_rdy after mem_ack.
REQ-004 Ports: clk in 1 (sole clock); rst_n in 1, asynchronous, active-low.
REQ-005 ioctl_upload in 1: HPS upload session active.
REQ-006 ioctl_rd in 1: single-cycle request for the byte at ioctl_addr.
REQ-007 ioctl_addr in AW: byte address of the request.
REQ-008 ioctl_din out 8: returned byte.
REQ-009 ioctl_wait out 1: stall to hps_io while a memory fetch is pending.
REQ-010 mem_req out 1 / mem_addr out AW-1: 16-bit word request, word address = ioctl_addr[AW-1:1].
REQ-011 mem_ack in 1 (request accepted); mem_rdy in 1 (mem_data valid); mem_data in 16.
REQ-012 upload_done out 1: one-cycle pulse at end of session.
REQ-013 err out 1: sticky error flag.

Function
REQ-014 FSM states: IDLE, REQ, WAIT; rd, ack, rdy, upload and counter sampled on rising clk.
REQ-015 One-word cache: cache_addr (AW-1 bits), cache_data (16), cache_valid.
REQ-016 IDLE, ioctl_rd, ioctl_addr>=DUMP_SIZE: ioctl_din=8'hFF next cycle; no memory access; ioctl_wait stays 0.
REQ-017 IDLE, ioctl_rd, hit (cache_valid and word match): ioctl_din=selected byte next cycle; ioctl_wait stays 0.
REQ-018 Byte select: addr[0]=0 -> data[7:0], addr[0]=1 -> data[15:8].
REQ-019 IDLE, ioctl_rd, miss: next cycle mem_req=1, mem_addr latched, ioctl_wait=1, state REQ.
REQ-020 REQ: mem_req held until the cycle mem_ack=1; then mem_req=0, counter cleared, state WAIT.
REQ-021 WAIT, mem_rdy: cache loaded, cache_valid=1, ioctl_din updated, ioctl_wait=0 next cycle, state IDLE.
REQ-022 WAIT, counter reaches TIMEOUT without mem_rdy: ioctl_din=8'hFF, err=1, cache_valid=0, ioctl_wait=0, state IDLE.
REQ-023 mem_ack and mem_rdy in the same REQ cycle: treated as ack then rdy, IDLE next cycle.
REQ-024 ioctl_rd outside IDLE: ignored, err=1.
REQ-025 mem_rdy in IDLE (stale data): ignored, cache unchanged.
REQ-026 Rising ioctl_upload: cache_valid=0, err=0.
REQ-027 Falling ioctl_upload: upload_done pulses one cycle; any fetch aborted (mem_req=0, ioctl_wait=0, state IDLE, cache_valid=0).
REQ-028 ioctl_rd with ioctl_upload=0: ignored.
REQ-029 Address compare is unsigned, full AW bits; counter saturates, never wraps.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, mem_req=0, mem_addr=0, ioctl_wait=0, ioctl_din=8'hFF, upload_done=0, err=0, cache_valid=0, counter=0.
REQ-031 Reset mid-fetch discards the fetch; a later mem_rdy falls under REQ-025.

Structure
REQ-032 Package jtframe_upload_pkg holds the FSM state enum and the constant FILL_BYTE=8'hFF.
REQ-033 Single module, no sub-modules; the timeout counter is inline.

Verification
REQ-034 Session start; rd at 0x0010, mem returns 16'hBEEF after 3 cycles -> ioctl_din=8'hEF, ioctl_wait high for exactly the fetch cycles; rd at 0x0011 -> 8'hBE next cycle, no mem_req.
REQ-035 DUMP_SIZE=0x2000; rd at 0x2000 -> ioctl_din=8'hFF, mem_req never asserted, ioctl_wait stays 0.
REQ-036 Miss with mem_rdy withheld, TIMEOUT=16 -> after 16 WAIT cycles ioctl_din=8'hFF, err=1, ioctl_wait=0; next session start clears err.
REQ-037 ioctl_upload drops during WAIT -> upload_done single pulse, ioctl_wait=0; late mem_rdy 16'h1234 ignored; new session rd at same word issues a new mem_req.
REQ-038 rst_n asserted during REQ -> all outputs reach reset values immediately, no clk edge required; mem_ack after release causes no transition.
